// File: rtl/fd_latch.sv
// ---------------------------------------------------------------------------
// fd_latch -- fetch/decode pipeline register
//
// Captures the fetched instruction word and its PC on each rising clock edge
// and splits the registered word into decode fields for the register file,
// the immediate sign-extender (sx_32bit) and the decode/execute latch.
// Supports stall (hold contents) and flush (insert a bubble). All outputs
// are derived from registered state only, so no input reaches an output
// combinationally.
//
// Ports:
//   clock      in   1   rising-edge clock
//   reset      in   1   asynchronous, active-low; clears all state
//   pc_in      in  32   PC+1 of the fetched instruction
//   insn_in    in  32   instruction word from instruction memory
//   in_valid   in   1   fetch stage presents a real instruction
//   stall      in   1   hold current contents
//   flush      in   1   replace contents with a bubble (wins over stall)
//   pc_out     out 32   registered PC
//   insn_out   out 32   registered instruction
//   valid_out  out  1   registered instruction is real
//   opcode/rd/rs/rt/shamt/aluop  out 5 each, bit slices of insn_out
//   imm17      out 17   insn_out[16:0], unextended (feeds sx_32bit)
//   target     out 27   insn_out[26:0]
//   is_r/is_i/is_j1/is_j2  out 1 each, one-hot class, 0 when not valid
//   held       out  1   contents were held on the previous edge
// ---------------------------------------------------------------------------
module fd_latch (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] insn_in,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] pc_out,
    output logic [31:0] insn_out,
    output logic        valid_out,
    output logic [4:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  shamt,
    output logic [4:0]  aluop,
    output logic [16:0] imm17,
    output logic [26:0] target,
    output logic        is_r,
    output logic        is_i,
    output logic        is_j1,
    output logic        is_j2,
    output logic        held
);

    // add $0,$0,$0 encodes as all zeros
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic [31:0] r_pc;
    logic [31:0] r_insn;
    logic        r_valid;
    logic        r_held;

    logic [4:0]  w_opcode;
    logic        w_is_r;
    logic        w_is_i;
    logic        w_is_j1;
    logic        w_is_j2;

    // ---- fetch -> decode register ----
    // Flush has priority over stall so a taken branch always squashes the
    // instruction even while the hazard unit is holding the pipe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc    <= 32'd0;
            r_insn  <= NOP;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
        end else if (flush) begin
            r_pc    <= 32'd0;
            r_insn  <= NOP;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
        end else if (stall) begin
            r_held  <= 1'b1;
        end else begin
            r_pc    <= pc_in;
            r_insn  <= in_valid ? insn_in : NOP;
            r_valid <= in_valid;
            // a fetch bubble is not a hold, so held stays low
            r_held  <= 1'b0;
        end
    end

    // ---- decode (combinational from registered word) ----
    assign w_opcode = r_insn[31:27];

    // Unlisted opcodes leave every class flag low while valid stays high;
    // downstream treats that as a NOP.
    always_comb begin
        w_is_r  = 1'b0;
        w_is_i  = 1'b0;
        w_is_j1 = 1'b0;
        w_is_j2 = 1'b0;
        if (r_valid) begin
            case (w_opcode)
                5'b00000:                               w_is_r  = 1'b1;
                5'b00101, 5'b00111, 5'b01000,
                5'b00010, 5'b00110:                     w_is_i  = 1'b1;
                5'b00001, 5'b00011, 5'b10101, 5'b10110: w_is_j1 = 1'b1;
                5'b00100:                               w_is_j2 = 1'b1;
                default: ;
            endcase
        end
    end

    assign pc_out    = r_pc;
    assign insn_out  = r_insn;
    assign valid_out = r_valid;
    assign held      = r_held;

    assign opcode = w_opcode;
    assign rd     = r_insn[26:22];
    assign rs     = r_insn[21:17];
    assign rt     = r_insn[16:12];
    assign shamt  = r_insn[11:7];
    assign aluop  = r_insn[6:2];
    assign imm17  = r_insn[16:0];
    assign target = r_insn[26:0];

    assign is_r  = w_is_r;
    assign is_i  = w_is_i;
    assign is_j1 = w_is_j1;
    assign is_j2 = w_is_j2;

endmodule

// File: tb/tb_fd_latch.sv
module tb_fd_latch;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] insn_in;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [31:0] pc_out;
    logic [31:0] insn_out;
    logic        valid_out;
    logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
    logic [16:0] imm17;
    logic [26:0] target;
    logic        is_r, is_i, is_j1, is_j2;
    logic        held;

    int n_tests = 0;
    int n_fail  = 0;

    fd_latch dut (
        .clock     (clock),
        .reset     (reset),
        .pc_in     (pc_in),
        .insn_in   (insn_in),
        .in_valid  (in_valid),
        .stall     (stall),
        .flush     (flush),
        .pc_out    (pc_out),
        .insn_out  (insn_out),
        .valid_out (valid_out),
        .opcode    (opcode),
        .rd        (rd),
        .rs        (rs),
        .rt        (rt),
        .shamt     (shamt),
        .aluop     (aluop),
        .imm17     (imm17),
        .target    (target),
        .is_r      (is_r),
        .is_i      (is_i),
        .is_j1     (is_j1),
        .is_j2     (is_j2),
        .held      (held)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a falling edge, clock one rising edge, and
    // return at the following falling edge where outputs are sampled.
    task automatic step(input logic [31:0] insn, input logic [31:0] pc,
                        input logic v, input logic st, input logic fl);
        insn_in  = insn;
        pc_in    = pc;
        in_valid = v;
        stall    = st;
        flush    = fl;
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [3:0] cls();
        return {is_r, is_i, is_j1, is_j2};
    endfunction

    // opcode -> expected {is_r,is_i,is_j1,is_j2}
    logic [4:0] op_tab  [10] = '{5'b00000, 5'b00111, 5'b01000, 5'b00010, 5'b00110,
                                 5'b00011, 5'b10101, 5'b10110, 5'b00100, 5'b01111};
    logic [3:0] cls_tab [10] = '{4'b1000, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                                 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0000};

    logic [31:0] sx;

    initial begin
        reset = 1'b0; pc_in = '0; insn_in = '0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        @(negedge clock);
        check("rst_insn",  insn_out, 32'h0);
        check("rst_pc",    pc_out, 32'h0);
        check("rst_valid", valid_out, 1'b0);
        check("rst_held",  held, 1'b0);
        check("rst_cls",   cls(), 4'b0000);
        reset = 1'b1;

        // load addi $1,$2,0x15555
        step(32'h2845_5555, 32'd7, 1'b1, 1'b0, 1'b0);
        check("addi_opcode", opcode, 5'b00101);
        check("addi_rd",     rd, 5'd1);
        check("addi_rs",     rs, 5'd2);
        check("addi_rt",     rt, 5'h15);
        check("addi_imm",    imm17, 17'h15555);
        check("addi_cls",    cls(), 4'b0100);
        check("addi_pc",     pc_out, 32'd7);
        check("addi_valid",  valid_out, 1'b1);
        check("addi_held",   held, 1'b0);
        sx = {{15{imm17[16]}}, imm17};
        check("addi_sx",     sx, 32'hFFFF_5555);

        // asynchronous reset mid-cycle, observed before the next rising edge
        #2 reset = 1'b0;
        #1;
        check("arst_insn",  insn_out, 32'h0);
        check("arst_pc",    pc_out, 32'h0);
        check("arst_valid", valid_out, 1'b0);
        check("arst_imm",   imm17, 17'h0);
        check("arst_cls",   cls(), 4'b0000);
        @(negedge clock);
        reset = 1'b1;

        // positive immediate
        step(32'h2800_0014, 32'd8, 1'b1, 1'b0, 1'b0);
        check("pimm_imm", imm17, 17'd20);
        check("pimm_cls", cls(), 4'b0100);
        check("pimm_pc",  pc_out, 32'd8);

        // stall for three edges with new fetch data waiting
        for (int i = 0; i < 3; i++) begin
            step(32'h0800_0010, 32'd9, 1'b1, 1'b1, 1'b0);
            check("stall_insn", insn_out, 32'h2800_0014);
            check("stall_pc",   pc_out, 32'd8);
            check("stall_held", held, 1'b1);
        end

        // release stall
        step(32'h0800_0010, 32'd9, 1'b1, 1'b0, 1'b0);
        check("rel_insn",   insn_out, 32'h0800_0010);
        check("rel_cls",    cls(), 4'b0010);
        check("rel_target", target, 27'h10);
        check("rel_held",   held, 1'b0);
        check("rel_pc",     pc_out, 32'd9);

        // flush together with stall
        step(32'h2845_5555, 32'd10, 1'b1, 1'b1, 1'b1);
        check("fl_insn",  insn_out, 32'h0);
        check("fl_pc",    pc_out, 32'h0);
        check("fl_valid", valid_out, 1'b0);
        check("fl_cls",   cls(), 4'b0000);
        check("fl_held",  held, 1'b0);

        // unknown opcode stays valid with no class
        step(32'hF800_0000, 32'd11, 1'b1, 1'b0, 1'b0);
        check("unk_valid",  valid_out, 1'b1);
        check("unk_opcode", opcode, 5'b11111);
        check("unk_cls",    cls(), 4'b0000);

        // fetch bubble
        step(32'h2845_5555, 32'd12, 1'b0, 1'b0, 1'b0);
        check("bub_insn",  insn_out, 32'h0);
        check("bub_valid", valid_out, 1'b0);
        check("bub_held",  held, 1'b0);
        check("bub_pc",    pc_out, 32'd12);

        // class decode across the opcode table
        for (int i = 0; i < 10; i++) begin
            step({op_tab[i], 27'h5A5_A5A5}, 32'd20 + i, 1'b1, 1'b0, 1'b0);
            check($sformatf("cls_op%0d", i), cls(), cls_tab[i]);
            check($sformatf("fld_op%0d", i), {shamt, aluop}, {5'b01011, 5'b01001});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
